// File: rtl/ps2_key_rx.sv
// ----------------------------------------------------------------------------
// ps2_key_rx
// PS/2 keyboard receiver for the scoreboard input path. Every flop is clocked
// by the system clock. The raw PS/2 lines are synchronised, and the clock line
// is deglitched. 11-bit frames are decoded with start, parity, stop and timeout
// checks. E0 and F0 prefixes become flags on the key event that follows them.
// Events are queued in a first-word fall-through FIFO with a valid/ready
// output.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   ps2k_clk    raw PS/2 clock (asynchronous)
//   ps2k_data   raw PS/2 data (asynchronous)
//   evt_ready   consumer accepts the head event
//   ovf_clr     single-cycle clear of the overflow flag
//   evt_valid   FIFO non-empty
//   evt_code    head scan code (0 when empty)
//   evt_break   head event is a release (0 when empty)
//   evt_ext     head event is extended (0 when empty)
//   fifo_count  number of entries held
//   overflow    sticky: an event was dropped on a full FIFO
//   frame_err   one-cycle pulse per rejected frame
//   err_count   saturating count of rejected frames
// ----------------------------------------------------------------------------
module ps2_key_rx #(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 5000,
   parameter int FIFO_DEPTH  = 8,
   parameter int ERR_W       = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               ps2k_clk,
   input  logic                               ps2k_data,
   input  logic                               evt_ready,
   input  logic                               ovf_clr,
   output logic                               evt_valid,
   output logic [7:0]                         evt_code,
   output logic                               evt_break,
   output logic                               evt_ext,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               overflow,
   output logic                               frame_err,
   output logic [ERR_W-1:0]                   err_count
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);

   localparam logic [FCW-1:0]   FLT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [FCW-1:0]   FLT_ONE  = FCW'(1);
   localparam logic [TCW-1:0]   TMO_LAST = TCW'(TIMEOUT_CYC);
   localparam logic [TCW-1:0]   TMO_ONE  = TCW'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Data byte plus parity bit must carry an odd number of ones.
   function automatic logic odd_ones(input logic [8:0] v);
      return ^v;
   endfunction

   // ---------------- synchronisers and clock filter ----------------
   logic           clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
   logic           dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
   logic           flt_lvl_q, flt_lvl_d;
   logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
   logic           strobe_s;

   // Synchroniser shift and glitch filter. The level flips only after it has
   // disagreed for FILTER_LEN consecutive samples. A flip to low is a strobe.
   always_comb begin
      clk_meta_d = ps2k_clk;
      clk_sync_d = clk_meta_q;
      dat_meta_d = ps2k_data;
      dat_sync_d = dat_meta_q;
      flt_lvl_d  = flt_lvl_q;
      flt_cnt_d  = flt_cnt_q;
      strobe_s   = 1'b0;
      if (clk_sync_q == flt_lvl_q) begin
         flt_cnt_d = {FCW{1'b0}};
      end else if (flt_cnt_q == FLT_LAST) begin
         flt_lvl_d = clk_sync_q;
         flt_cnt_d = {FCW{1'b0}};
         strobe_s  = ~clk_sync_q;
      end else begin
         flt_cnt_d = flt_cnt_q + FLT_ONE;
      end
   end

   // Input conditioning registers. The idle bus is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         flt_lvl_q  <= 1'b1;
         flt_cnt_q  <= {FCW{1'b0}};
      end else begin
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
         flt_lvl_q  <= flt_lvl_d;
         flt_cnt_q  <= flt_cnt_d;
      end
   end

   // ---------------- frame FSM ----------------
   state_t         state_q, state_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic           par_ok_q, par_ok_d;
   logic [TCW-1:0] tmo_q, tmo_d;
   logic           byte_ok_s, reject_s;

   // Next-state logic for the frame. A fresh strobe outranks a timeout that
   // expires in the same cycle.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      tmo_d     = tmo_q;
      byte_ok_s = 1'b0;
      reject_s  = 1'b0;
      if (state_q == ST_IDLE) begin
         tmo_d = {TCW{1'b0}};
         if (strobe_s && !dat_sync_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (strobe_s) begin
         tmo_d = {TCW{1'b0}};
         case (state_q)
            ST_DATA: begin
               shift_d   = {dat_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_PARITY;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               par_ok_d = odd_ones({shift_q, dat_sync_q});
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (dat_sync_q && par_ok_q) begin
                  byte_ok_s = 1'b1;
               end else begin
                  reject_s = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (tmo_q == TMO_LAST) begin
         state_d  = ST_IDLE;
         tmo_d    = {TCW{1'b0}};
         reject_s = 1'b1;
      end else begin
         tmo_d = tmo_q + TMO_ONE;
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         par_ok_q  <= 1'b0;
         tmo_q     <= {TCW{1'b0}};
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_ok_q  <= par_ok_d;
         tmo_q     <= tmo_d;
      end
   end

   // ---------------- prefix decoder and error accounting ----------------
   logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
   logic             push_q, push_d;
   logic [9:0]       word_q, word_d;      // {break, ext, code}
   logic             frame_err_q, frame_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Fold E0/F0 into pending flags. Any other good byte becomes an event.
   always_comb begin
      ext_pend_d  = ext_pend_q;
      brk_pend_d  = brk_pend_q;
      push_d      = 1'b0;
      word_d      = word_q;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (reject_s) begin
         ext_pend_d  = 1'b0;
         brk_pend_d  = 1'b0;
         frame_err_d = 1'b1;
         if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else if (byte_ok_s) begin
         if (shift_q == 8'hE0) begin
            ext_pend_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_pend_d = 1'b1;
         end else begin
            push_d     = 1'b1;
            word_d     = {brk_pend_q, ext_pend_q, shift_q};
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
         end
      end else begin
         push_d = 1'b0;
      end
   end

   // Decoder registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
         push_q      <= 1'b0;
         word_q      <= 10'd0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= {ERR_W{1'b0}};
      end else begin
         ext_pend_q  <= ext_pend_d;
         brk_pend_q  <= brk_pend_d;
         push_q      <= push_d;
         word_q      <= word_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // ---------------- event FIFO ----------------
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [9:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          valid_q, valid_d;
   logic [9:0]    head_q, head_d;
   logic          pop_s, full_s, wr_en_s, drop_s;

   // FIFO control. A pop on a full FIFO frees the slot for a simultaneous
   // push. The head registers show the entry that will be at the read
   // pointer next cycle, including a word being written into that slot.
   always_comb begin
      mem_d    = mem_q;
      pop_s    = (cnt_q != {CW{1'b0}}) && evt_ready;
      full_s   = (cnt_q == CNT_FULL);
      wr_en_s  = push_q && (!full_s || pop_s);
      drop_s   = push_q && full_s && !pop_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_s) begin
         mem_d[wr_ptr_q] = word_q;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      valid_d = (cnt_d != {CW{1'b0}});
      if (!valid_d) begin
         head_d = 10'd0;
      end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = word_q;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // FIFO storage, pointers and registered head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 10'd0;
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         head_q   <= 10'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   assign evt_valid  = valid_q;
   assign evt_code   = head_q[7:0];
   assign evt_ext    = head_q[8];
   assign evt_break  = head_q[9];
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
`timescale 1ns/1ps
module tb_ps2_key_rx;

   localparam int DEPTH = 4;
   localparam int TMO   = 300;
   localparam int H     = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2k_clk = 1'b1;
   logic       ps2k_data = 1'b1;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       evt_valid, evt_break, evt_ext, overflow, frame_err;
   logic [7:0] evt_code, err_count;
   logic [2:0] fifo_count;

   ps2_key_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
      .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
      .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
      .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         err_pulses = 0;
   int         exp_rej = 0;
   logic [7:0] exp_err = 8'd0;
   bit         m_brk = 1'b0;
   bit         m_ext = 1'b0;
   bit         exp_ovf = 1'b0;
   bit         rand_ready = 1'b0;
   logic [9:0] exp_q [$];
   logic [9:0] mon_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Reference model: a key event is a good non-prefix byte carrying the
   // prefixes seen since the last event or rejection.
   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) begin
         m_brk = 1'b0; m_ext = 1'b0; exp_rej++;
         if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
         else exp_q.push_back({m_brk, m_ext, b});
         m_brk = 1'b0; m_ext = 1'b0;
      end
   endtask

   task automatic glitch();
      ps2k_clk = 1'b0;
      tick(2);
      ps2k_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int glitch_at, input int h);
      logic [10:0] bits;
      bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2k_data = bits[i];
         if (i == glitch_at) begin
            tick(h / 2); glitch(); tick(h - h / 2 - 2);
         end else begin
            tick(h);
         end
         ps2k_clk = 1'b0;
         tick(h);
         ps2k_clk = 1'b1;
      end
      ps2k_data = 1'b1;
      tick(30);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      logic [8:0] bits;
      bits = {b, 1'b0};
      for (int i = 0; i <= nbits; i++) begin
         ps2k_data = bits[i];
         tick(H);
         ps2k_clk = 1'b0;
         tick(H);
         ps2k_clk = 1'b1;
      end
      ps2k_data = 1'b1;
      tick(10);
   endtask

   task automatic send_good(input logic [7:0] b);
      model_frame(b, 1'b1);
      send_frame(b, 1'b0, 1'b0, -1, H);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
      chk("drain_pending", exp_q.size(), 0);
   endtask

   // Scoreboard monitor: compare every accepted event and count error pulses.
   always @(negedge clk) begin
      if (reset) begin
         if (frame_err) err_pulses++;
         if (evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL evt_unexpected actual=%h required=none", {evt_break, evt_ext, evt_code});
            end else begin
               mon_w = exp_q.pop_front();
               if ({evt_break, evt_ext, evt_code} !== mon_w) begin
                  failures++;
                  $display("FAIL evt_pop actual=%h required=%h", {evt_break, evt_ext, evt_code}, mon_w);
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [7:0] b;
      bit bp, bs;
      tick(4);
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_break", evt_break, 0);
      chk("rst_ext", evt_ext, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_errcnt", err_count, 0);
      reset = 1'b1;
      tick(10);

      // Make code held with evt_ready low, then a single pop.
      send_good(8'h1C);
      chk("mk_valid", evt_valid, 1);
      chk("mk_code", evt_code, 8'h1C);
      chk("mk_break", evt_break, 0);
      chk("mk_ext", evt_ext, 0);
      chk("mk_count", fifo_count, 1);
      evt_ready = 1'b1;
      tick(1);
      chk("mk_pop_valid", evt_valid, 0);
      chk("mk_pop_code", evt_code, 0);
      rand_ready = 1'b1;

      // Extended release followed by a plain make.
      send_good(8'hE0); send_good(8'hF0); send_good(8'h75); send_good(8'h75);
      wait_drain();

      // Parity error clears a pending F0.
      send_good(8'hF0);
      model_frame(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0, -1, H);
      chk("par_errcnt", err_count, exp_err);
      chk("par_pulses", err_pulses, exp_rej);
      send_good(8'h1B);
      wait_drain();

      // Timeout after start plus three data bits.
      model_frame(8'h00, 1'b0);
      send_partial(8'h29, 3);
      tick(TMO + 50);
      chk("tmo_errcnt", err_count, exp_err);
      chk("tmo_pulses", err_pulses, exp_rej);
      send_good(8'h29);
      wait_drain();

      // Overflow with the consumer stalled.
      rand_ready = 1'b0;
      evt_ready = 1'b0;
      tick(2);
      send_good(8'h1C); send_good(8'h1B); send_good(8'h42); send_good(8'h4B); send_good(8'h29);
      chk("ovf_count", fifo_count, DEPTH);
      chk("ovf_flag", overflow, exp_ovf);
      chk("ovf_head", evt_code, 8'h1C);
      evt_ready = 1'b1;
      tick(1);
      chk("ovf_pop_count", fifo_count, DEPTH - 1);
      wait_drain();
      chk("ovf_sticky", overflow, exp_ovf);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      chk("ovf_clr", overflow, exp_ovf);

      // Short low pulses on the clock line while idle and mid-frame.
      rand_ready = 1'b1;
      tick(20); glitch(); tick(20); glitch(); tick(20);
      chk("glitch_idle_count", fifo_count, 0);
      chk("glitch_idle_err", err_count, exp_err);
      model_frame(8'h42, 1'b1);
      send_frame(8'h42, 1'b0, 1'b0, 4, H);
      wait_drain();
      chk("glitch_err", err_count, exp_err);

      // Reset in the middle of a frame drops the partial frame and a pending E0.
      send_good(8'hE0);
      send_partial(8'h55, 5);
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
      m_brk = 1'b0; m_ext = 1'b0; exp_err = 8'd0; exp_q.delete();
      tick(5);
      chk("midrst_errcnt", err_count, 0);
      chk("midrst_valid", evt_valid, 0);
      send_good(8'h1C);
      wait_drain();

      // Random traffic including prefixes and corrupted frames.
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hE0;
            2:       b = 8'hF0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bp = 1'b0; bs = 1'b0;
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 1) bp = 1'b1;
            else bs = 1'b1;
         end
         model_frame(b, !(bp || bs));
         send_frame(b, bp, bs, -1, int'($urandom_range(12, 28)));
      end
      wait_drain();

      chk("end_errcnt", err_count, exp_err);
      chk("end_pulses", err_pulses, exp_rej);
      chk("end_ovf", overflow, exp_ovf);
      chk("end_count", fifo_count, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
